// File: rtl/eth_pkg.sv
// Shared Ethernet receive definitions: framer states, MII nibble codes, CRC-32 constants
// and default frame length limits.
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_e;

    localparam logic [3:0]  ETH_PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  ETH_SFD_NIB      = 4'hD;
    localparam logic [31:0] ETH_CRC_POLY     = 32'h04C11DB7;
    localparam logic [31:0] ETH_CRC_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] ETH_CRC_RESIDUE  = 32'hC704DD7B;

    localparam int ETH_MIN_LEN = 64;
    localparam int ETH_MAX_LEN = 1518;

    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational CRC-32 byte step (reflected, LSB first); shared by the receive and transmit paths.
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    localparam logic [31:0] CRC_POLY_REFL = bit_rev32(ETH_CRC_POLY);

    logic [31:0] w_c;

    always_comb begin
        w_c = i_crc;
        for (int i = 0; i < 8; i++) begin
            if (w_c[0] ^ i_data[i]) begin
                w_c = (w_c >> 1) ^ CRC_POLY_REFL;
            end else begin
                w_c = w_c >> 1;
            end
        end
    end

    assign o_crc = w_c;

endmodule

// File: rtl/mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, packs nibbles (low first) into a delimited byte stream.
// Defining MII_RX_FCS_CHECK_EN adds a CRC-32 residue check that flags bad frames.
module mii_rx_framer
    import eth_pkg::*;
#(
    parameter int MAX_LEN = ETH_MAX_LEN,
    parameter int MIN_LEN = ETH_MIN_LEN,
    parameter int LEN_W   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       phy_rxd,
    input  logic             phy_rx_dv,
    input  logic             phy_rx_er,
    output logic [7:0]       m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast,
    output logic             m_tuser,
    output logic [LEN_W-1:0] frame_len,
    output logic             stat_ok,
    output logic             stat_err
);

    // Stream: m_tvalid is a one-cycle strobe with no ready; downstream must take every byte.
    // m_tlast and m_tuser are meaningful only while m_tvalid is high.

    logic [3:0]       r_rxd;
    logic             r_dv;
    logic             r_er;
    rx_state_e        r_state;
    logic             r_phase;
    logic [3:0]       r_lo;
    logic [7:0]       r_held;
    logic             r_have_held;
    logic [LEN_W-1:0] r_count;
    logic             r_err;
    logic             r_eof_pend;
    logic             r_eof_err;

    logic [7:0]       r_tdata;
    logic             r_tvalid;
    logic             r_tlast;
    logic             r_tuser;
    logic [LEN_W-1:0] r_frame_len;
    logic             r_stat_ok;
    logic             r_stat_err;

    logic [7:0]       w_byte;
    logic [LEN_W-1:0] w_count_inc;
    logic             w_over;
    logic             w_sfd_hit;
    logic             w_byte_done;
    logic             w_fcs_bad;
    logic             w_eof_err;

    assign w_byte      = {r_rxd, r_lo};
    assign w_count_inc = (r_count == {LEN_W{1'b1}}) ? r_count : r_count + 1'b1;
    assign w_over      = (r_count >= LEN_W'(MAX_LEN));
    assign w_sfd_hit   = (r_state == ST_PREAMBLE) && r_dv && (r_rxd == ETH_SFD_NIB);
    assign w_byte_done = (r_state == ST_DATA) && r_dv && r_phase && !w_over;
    // r_phase still high at end of frame means a dribble nibble was left unpaired
    assign w_eof_err   = r_err | r_phase | (r_count < LEN_W'(MIN_LEN)) | w_fcs_bad;

`ifdef MII_RX_FCS_CHECK_EN
    logic [31:0] r_crc;
    logic [31:0] w_crc_next;

    eth_crc32_byte u_crc (
        .i_crc  (r_crc),
        .i_data (w_byte),
        .o_crc  (w_crc_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_crc <= ETH_CRC_INIT;
        end else if (w_sfd_hit) begin
            r_crc <= ETH_CRC_INIT;
        end else if (w_byte_done) begin
            r_crc <= w_crc_next;
        end
    end

    // The register shifts LSB first, so reverse it before comparing to the MSB-first residue.
    assign w_fcs_bad = (bit_rev32(r_crc) != ETH_CRC_RESIDUE);
`else
    assign w_fcs_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rxd       <= '0;
            r_dv        <= 1'b0;
            r_er        <= 1'b0;
            r_state     <= ST_IDLE;
            r_phase     <= 1'b0;
            r_lo        <= '0;
            r_held      <= '0;
            r_have_held <= 1'b0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_eof_pend  <= 1'b0;
            r_eof_err   <= 1'b0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tuser     <= 1'b0;
            r_frame_len <= '0;
            r_stat_ok   <= 1'b0;
            r_stat_err  <= 1'b0;
        end else begin
            r_rxd      <= phy_rxd;
            r_dv       <= phy_rx_dv;
            r_er       <= phy_rx_er;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_tuser    <= 1'b0;
            r_stat_ok  <= 1'b0;
            r_stat_err <= 1'b0;

            // Closing byte goes out one cycle after detection so strobes never land back to back.
            if (r_eof_pend) begin
                r_eof_pend  <= 1'b0;
                r_have_held <= 1'b0;
                r_stat_ok   <= r_have_held && !r_eof_err;
                r_stat_err  <= !r_have_held || r_eof_err;
                if (r_have_held) begin
                    r_tvalid    <= 1'b1;
                    r_tdata     <= r_held;
                    r_tlast     <= 1'b1;
                    r_tuser     <= r_eof_err;
                    r_frame_len <= r_count;
                end else begin
                    r_frame_len <= '0;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_dv) begin
                        r_state <= (r_rxd == ETH_PREAMBLE_NIB) ? ST_PREAMBLE : ST_DROP;
                    end
                end
                ST_PREAMBLE: begin
                    if (!r_dv) begin
                        r_state <= ST_IDLE;
                    end else if (w_sfd_hit) begin
                        r_state     <= ST_DATA;
                        r_phase     <= 1'b0;
                        r_err       <= 1'b0;
                        r_count     <= '0;
                        r_have_held <= 1'b0;
                    end else if (r_rxd != ETH_PREAMBLE_NIB) begin
                        r_state <= ST_DROP;
                    end
                end
                ST_DATA: begin
                    if (!r_dv) begin
                        r_state    <= ST_IDLE;
                        r_eof_pend <= 1'b1;
                        r_eof_err  <= w_eof_err;
                    end else begin
                        if (r_er) begin
                            r_err <= 1'b1;
                        end
                        if (!r_phase) begin
                            r_lo    <= r_rxd;
                            r_phase <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            if (w_over) begin
                                r_tvalid    <= 1'b1;
                                r_tdata     <= r_held;
                                r_tlast     <= 1'b1;
                                r_tuser     <= 1'b1;
                                r_frame_len <= LEN_W'(MAX_LEN);
                                r_stat_err  <= 1'b1;
                                r_have_held <= 1'b0;
                                r_state     <= ST_DROP;
                            end else begin
                                if (r_have_held) begin
                                    r_tvalid <= 1'b1;
                                    r_tdata  <= r_held;
                                end
                                r_held      <= w_byte;
                                r_have_held <= 1'b1;
                                r_count     <= w_count_inc;
                            end
                        end
                    end
                end
                default: begin
                    if (!r_dv) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign m_tdata   = r_tdata;
    assign m_tvalid  = r_tvalid;
    assign m_tlast   = r_tlast;
    assign m_tuser   = r_tuser;
    assign frame_len = r_frame_len;
    assign stat_ok   = r_stat_ok;
    assign stat_err  = r_stat_err;

endmodule

// File: tb/tb_mii_rx_framer.sv
// Bench for mii_rx_framer: nibble-level driver, expected-byte and expected-status queues,
// and a monitor that checks every strobe the framer produces.
module tb_mii_rx_framer;

    localparam int MAX_LEN = 1518;
    localparam int MIN_LEN = 64;
    localparam int LEN_W   = 11;
    localparam int W       = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [3:0]       phy_rxd = 4'h0;
    logic             phy_rx_dv = 1'b0;
    logic             phy_rx_er = 1'b0;
    logic [7:0]       m_tdata;
    logic             m_tvalid;
    logic             m_tlast;
    logic             m_tuser;
    logic [LEN_W-1:0] frame_len;
    logic             stat_ok;
    logic             stat_err;

    mii_rx_framer #(
        .MAX_LEN (MAX_LEN),
        .MIN_LEN (MIN_LEN),
        .LEN_W   (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .phy_rxd   (phy_rxd),
        .phy_rx_dv (phy_rx_dv),
        .phy_rx_er (phy_rx_er),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tuser   (m_tuser),
        .frame_len (frame_len),
        .stat_ok   (stat_ok),
        .stat_err  (stat_err)
    );

    // ---------------- clock / reset ----------------
    always #20 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int               n_checks = 0;
    int               n_fail = 0;
    logic [W-1:0]     exp_q[$];       // {tdata, tlast, tuser}
    logic [12:0]      stat_q[$];      // {stat_ok, stat_err, frame_len}
    logic [7:0]       tx_bytes[$];
    bit               abort_mode = 1'b0;
    int               abort_events = 0;
    int               n_strobes = 0;
    int               n_stats = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else r = r >> 1;
        end
        return r;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic         prev_valid;
        logic [W-1:0] e;
        logic [12:0]  s;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (m_tvalid) begin
                    n_strobes++;
                    check("tvalid_spacing", {31'd0, prev_valid}, 32'd0);
                    if (abort_mode) begin
                        if (m_tlast) abort_events++;
                    end else if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got data 0x%0h last %0b user %0b, expected none",
                                 m_tdata, m_tlast, m_tuser);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", {22'd0, m_tdata, m_tlast, m_tuser}, {22'd0, e});
                    end
                end
                if (stat_ok || stat_err) begin
                    n_stats++;
                    if (abort_mode) begin
                        abort_events++;
                    end else if (stat_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_stat: got ok %0b err %0b len %0d, expected none",
                                 stat_ok, stat_err, frame_len);
                    end else begin
                        s = stat_q.pop_front();
                        check("stat", {19'd0, stat_ok, stat_err, frame_len}, {19'd0, s});
                    end
                end
                prev_valid = m_tvalid;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic nib(input logic [3:0] d, input logic dv, input logic er);
        @(negedge clk);
        phy_rxd   = d;
        phy_rx_dv = dv;
        phy_rx_er = er;
    endtask

    task automatic idle(input int n);
        repeat (n) nib(4'h0, 1'b0, 1'b0);
    endtask

    task automatic fill(input int n, input logic [7:0] seed);
        tx_bytes.delete();
        for (int i = 0; i < n; i++) tx_bytes.push_back(seed + 8'(i));
    endtask

    // 15 preamble nibbles then SFD nibble, i.e. 7 bytes of 0x55 and 0xD5; bad_pre injects a 0x3.
    task automatic send_body(input int er_nib, input bit bad_pre);
        logic [7:0] b;
        for (int i = 0; i < 15; i++) nib((bad_pre && i == 2) ? 4'h3 : 4'h5, 1'b1, 1'b0);
        nib(4'hD, 1'b1, 1'b0);
        for (int i = 0; i < tx_bytes.size(); i++) begin
            b = tx_bytes[i];
            nib(b[3:0], 1'b1, (2 * i == er_nib));
            nib(b[7:4], 1'b1, (2 * i + 1 == er_nib));
        end
    endtask

    task automatic send_frame(input int er_nib, input bit odd);
        send_body(er_nib, 1'b0);
        if (odd) nib(4'hA, 1'b1, 1'b0);
        idle(1);
    endtask

    // Hand model of the framer output for the frame held in tx_bytes.
    task automatic expect_frame(input bit er, input bit odd);
        int          n;
        int          eff;
        bit          over;
        bit          err;
        bit          last;
        logic [31:0] c;
        n    = tx_bytes.size();
        over = (n > MAX_LEN);
        eff  = over ? MAX_LEN : n;
        err  = er || odd || (n < MIN_LEN) || over;
        c    = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) c = crc_byte(c, tx_bytes[i]);
`ifdef MII_RX_FCS_CHECK_EN
        if (c != 32'hDEBB20E3) err = 1'b1;
`endif
        for (int i = 0; i < eff; i++) begin
            last = (i == eff - 1);
            exp_q.push_back({tx_bytes[i], last, last && err});
        end
        stat_q.push_back({!err, err, LEN_W'(eff)});
    endtask

    task automatic append_fcs();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < tx_bytes.size(); i++) c = crc_byte(c, tx_bytes[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) tx_bytes.push_back(c[8*i +: 8]);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || stat_q.size() != 0) && t < 40) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check({name, "_drain"}, exp_q.size() + stat_q.size(), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s0;
        int t0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {12'd0, m_tdata, m_tvalid, m_tlast, m_tuser, frame_len, stat_ok, stat_err}, 32'd0);
        rst = 1'b1;
        idle(4);

        // good 64-byte frame 0x00..0x3F
        fill(64, 8'h00);
        expect_frame(1'b0, 1'b0);
        send_frame(-1, 1'b0);
        drain("good64");
        check("good64_frame_len", {21'd0, frame_len}, 32'd64);

        // receive error on one nibble mid-frame
        fill(64, 8'h00);
        expect_frame(1'b1, 1'b0);
        send_frame(61, 1'b0);
        drain("rx_er");

        // runt frame
        fill(60, 8'h40);
        expect_frame(1'b0, 1'b0);
        send_frame(-1, 1'b0);
        drain("runt60");
        check("runt60_frame_len", {21'd0, frame_len}, 32'd60);

        // overlength frame, truncated at MAX_LEN, then a normal frame
        fill(1600, 8'h00);
        expect_frame(1'b0, 1'b0);
        send_frame(-1, 1'b0);
        drain("over1600");
        check("over_frame_len", {21'd0, frame_len}, 32'd1518);
        fill(64, 8'h80);
        expect_frame(1'b0, 1'b0);
        send_frame(-1, 1'b0);
        drain("after_over");

        // dribble nibble: 129 nibbles after SFD
        fill(64, 8'h20);
        expect_frame(1'b0, 1'b1);
        send_frame(-1, 1'b1);
        drain("odd_nibble");

        // preamble corrupted with 0x3: nothing at all comes out
        s0 = n_strobes + n_stats;
        fill(64, 8'h00);
        send_body(-1, 1'b1);
        idle(8);
        check("bad_preamble_silent", n_strobes + n_stats - s0, 32'd0);

        // back-to-back frames with a single dv-low cycle between them
        fill(64, 8'h11);
        expect_frame(1'b0, 1'b0);
        send_frame(-1, 1'b0);
        fill(70, 8'hC0);
        expect_frame(1'b0, 1'b0);
        send_frame(-1, 1'b0);
        drain("back_to_back");
        check("b2b_frame_len", {21'd0, frame_len}, 32'd70);

        // FCS: valid trailer, then a single flipped data bit
        fill(60, 8'h05);
        append_fcs();
        expect_frame(1'b0, 1'b0);
        send_frame(-1, 1'b0);
        drain("fcs_good");
        tx_bytes[10] = tx_bytes[10] ^ 8'h04;
        expect_frame(1'b0, 1'b0);
        send_frame(-1, 1'b0);
        drain("fcs_flip");

        // reset mid-frame: outputs clear at once and the aborted frame never closes
        abort_mode   = 1'b1;
        abort_events = 0;
        fill(20, 8'h33);
        send_body(-1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_outputs", {12'd0, m_tdata, m_tvalid, m_tlast, m_tuser, frame_len, stat_ok, stat_err}, 32'd0);
        phy_rx_dv = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        t0 = 0;
        while (t0 < 6) begin
            @(negedge clk);
            t0++;
        end
        abort_mode = 1'b0;
        check("abort_no_tlast", abort_events, 32'd0);
        fill(64, 8'h55);
        expect_frame(1'b0, 1'b0);
        send_frame(-1, 1'b0);
        drain("after_abort");

        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
